// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared definitions for the PS/2 keyboard-side transmitter.
//               Holds the break prefix byte, the frame length, the transmitter
//               state encoding and the odd-parity helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK      = 8'hF0;
    localparam int         PS2_FRAME_BITS = 11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        SHIFT  = 2'd2,
        GAP    = 2'd3
    } ps2_state_t;

    // Odd parity: the parity bit makes the total count of ones in
    // data + parity odd.
    function automatic logic ps2_odd_parity(input logic [7:0] i_data);
        return ~^i_data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_ascii2scan.sv
`default_nettype none
// ============================================================================
// Module      : ps2_ascii2scan
// Description : Combinational ASCII to PS/2 Set-2 scancode table.
//               Covers a-z (A-Z folded onto the same codes), 0-9, space,
//               enter (0x0D) and backspace (0x08). Anything else misses.
// Ports       : i_ascii    - ASCII code to translate
//               o_hit      - 1 when the code has a scancode
//               o_scancode - Set-2 make code (0 on miss)
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_ascii2scan (
    input  logic [7:0] i_ascii,
    output logic       o_hit,
    output logic [7:0] o_scancode
);

    logic [7:0] w_lc;

    // Upper-case letters share the lower-case key.
    assign w_lc = ((i_ascii >= 8'h41) && (i_ascii <= 8'h5A)) ? (i_ascii | 8'h20) : i_ascii;

    always_comb begin
        o_hit      = 1'b1;
        o_scancode = 8'h00;
        case (w_lc)
            8'h61: o_scancode = 8'h1C;  // a
            8'h62: o_scancode = 8'h32;  // b
            8'h63: o_scancode = 8'h21;  // c
            8'h64: o_scancode = 8'h23;  // d
            8'h65: o_scancode = 8'h24;  // e
            8'h66: o_scancode = 8'h2B;  // f
            8'h67: o_scancode = 8'h34;  // g
            8'h68: o_scancode = 8'h33;  // h
            8'h69: o_scancode = 8'h43;  // i
            8'h6A: o_scancode = 8'h3B;  // j
            8'h6B: o_scancode = 8'h42;  // k
            8'h6C: o_scancode = 8'h4B;  // l
            8'h6D: o_scancode = 8'h3A;  // m
            8'h6E: o_scancode = 8'h31;  // n
            8'h6F: o_scancode = 8'h44;  // o
            8'h70: o_scancode = 8'h4D;  // p
            8'h71: o_scancode = 8'h15;  // q
            8'h72: o_scancode = 8'h2D;  // r
            8'h73: o_scancode = 8'h1B;  // s
            8'h74: o_scancode = 8'h2C;  // t
            8'h75: o_scancode = 8'h3C;  // u
            8'h76: o_scancode = 8'h2A;  // v
            8'h77: o_scancode = 8'h1D;  // w
            8'h78: o_scancode = 8'h22;  // x
            8'h79: o_scancode = 8'h35;  // y
            8'h7A: o_scancode = 8'h1A;  // z
            8'h30: o_scancode = 8'h45;  // 0
            8'h31: o_scancode = 8'h16;  // 1
            8'h32: o_scancode = 8'h1E;  // 2
            8'h33: o_scancode = 8'h26;  // 3
            8'h34: o_scancode = 8'h25;  // 4
            8'h35: o_scancode = 8'h2E;  // 5
            8'h36: o_scancode = 8'h36;  // 6
            8'h37: o_scancode = 8'h3D;  // 7
            8'h38: o_scancode = 8'h3E;  // 8
            8'h39: o_scancode = 8'h46;  // 9
            8'h20: o_scancode = 8'h29;  // space
            8'h0D: o_scancode = 8'h5A;  // enter
            8'h08: o_scancode = 8'h66;  // backspace
            default: begin
                o_hit      = 1'b0;
                o_scancode = 8'h00;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ps2_kbd_tx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_kbd_tx
// Description : PS/2 keyboard-side transmitter. Takes ASCII key events,
//               maps them to Set-2 scancodes and sends make (and optionally
//               break) bytes as 11-bit device-to-host frames.
//               Build option PS2_KBD_TX_BREAK_EN: when defined, release events
//               send F0 followed by the code; when undefined, mapped release
//               events are accepted and dropped silently.
// Ports       : clk, rst             - system clock, sync active-high reset
//               in_valid/in_ready    - key event handshake
//               in_ascii, in_release - event payload (latched on accept)
//               ps2_clk, ps2_data    - PS/2 lines, idle high
//               busy                 - event in progress
//               err                  - one-cycle pulse on unmapped code
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_kbd_tx
    import ps2_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_ascii,
    input  logic       in_release,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy,
    output logic       err
);

`ifdef PS2_KBD_TX_BREAK_EN
    localparam logic c_BREAK_EN = 1'b1;
`else
    localparam logic c_BREAK_EN = 1'b0;
`endif

    localparam int                 c_DIV_W    = $clog2(2 * CLK_DIV);
    localparam int                 c_GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(2 * CLK_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_HIGH = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_CYCLES - 1);
    localparam logic [3:0]         c_BIT_LAST = 4'(PS2_FRAME_BITS - 1);

    ps2_state_t         r_state;
    logic [7:0]         r_ascii;
    logic               r_release;
    logic [c_DIV_W-1:0] r_div;
    logic [3:0]         r_bit;
    logic [c_GAP_W-1:0] r_gap;
    logic               r_byte_idx;
    logic               r_two_bytes;
    logic [7:0]         r_byte0;
    logic [7:0]         r_byte1;
    logic               r_ps2_clk;
    logic               r_ps2_data;

    logic               w_hit;
    logic [7:0]         w_scancode;
    logic               w_send;
    logic [7:0]         w_cur_byte;
    logic [10:0]        w_frame;
    logic [3:0]         w_next_bit;

    ps2_ascii2scan u_map (
        .i_ascii    (r_ascii),
        .o_hit      (w_hit),
        .o_scancode (w_scancode)
    );

    // A mapped release is only transmitted when break codes are enabled.
    assign w_send     = w_hit && (!r_release || c_BREAK_EN);
    assign w_cur_byte = r_byte_idx ? r_byte1 : r_byte0;
    assign w_frame    = {1'b1, ps2_odd_parity(w_cur_byte), w_cur_byte, 1'b0};
    assign w_next_bit = r_bit + 4'd1;

    assign in_ready = (r_state == IDLE);
    assign busy     = !in_ready;
    assign err      = (r_state == LOOKUP) && !w_hit;
    assign ps2_clk  = r_ps2_clk;
    assign ps2_data = r_ps2_data;

    // Line outputs are registered: each transition writes the value the
    // lines must carry in the first cycle of the next bit/state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ascii     <= 8'h00;
            r_release   <= 1'b0;
            r_div       <= '0;
            r_bit       <= 4'd0;
            r_gap       <= '0;
            r_byte_idx  <= 1'b0;
            r_two_bytes <= 1'b0;
            r_byte0     <= 8'h00;
            r_byte1     <= 8'h00;
            r_ps2_clk   <= 1'b1;
            r_ps2_data  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_ascii   <= in_ascii;
                        r_release <= in_release;
                        r_state   <= LOOKUP;
                    end
                end

                LOOKUP: begin
                    if (!w_send) begin
                        r_state <= IDLE;
                    end else begin
                        r_two_bytes <= r_release;
                        r_byte0     <= r_release ? PS2_BREAK : w_scancode;
                        r_byte1     <= w_scancode;
                        r_byte_idx  <= 1'b0;
                        r_div       <= '0;
                        r_bit       <= 4'd0;
                        r_ps2_clk   <= 1'b1;
                        r_ps2_data  <= 1'b0;  // start bit
                        r_state     <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (r_div == c_DIV_LAST) begin
                        r_div <= '0;
                        if (r_bit == c_BIT_LAST) begin
                            r_bit      <= 4'd0;
                            r_ps2_clk  <= 1'b1;
                            r_ps2_data <= 1'b1;
                            r_state    <= GAP;
                        end else begin
                            r_bit      <= w_next_bit;
                            r_ps2_clk  <= 1'b1;
                            r_ps2_data <= w_frame[w_next_bit];
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                        // Falling edge after the high half; host samples here.
                        if (r_div == c_DIV_HIGH) begin
                            r_ps2_clk <= 1'b0;
                        end
                    end
                end

                GAP: begin
                    if (r_gap == c_GAP_LAST) begin
                        r_gap <= '0;
                        if (r_two_bytes && !r_byte_idx) begin
                            r_byte_idx <= 1'b1;
                            r_div      <= '0;
                            r_bit      <= 4'd0;
                            r_ps2_clk  <= 1'b1;
                            r_ps2_data <= 1'b0;  // start bit of second byte
                            r_state    <= SHIFT;
                        end else begin
                            r_byte_idx <= 1'b0;
                            r_state    <= IDLE;
                        end
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
